// File: rtl/nf10_rate_limiter_token_bucket.sv
// ---------------------------------------------------------------------------
// nf10_rate_limiter_token_bucket
//
// Inline AXI4-Stream rate limiter built around a byte-accurate token bucket.
// The datapath is a zero-latency, unbuffered pass-through. Only the handshake
// is gated, and only at packet boundaries: once the first beat of a packet
// has been admitted, the rest of the packet always follows.
//
// The bucket is credited with tokens_per_interval bytes once every
// interval_cycles+1 cycles. It is debited by the byte count of every
// transferred beat, and it is capped at bucket_max. It may run negative:
// after a large packet the next packet waits until the count is back above
// zero.
//
// Ports
//   axi_aclk, axi_areset         clock; asynchronous active-high reset
//   s_axis_*                     slave stream (tdata/tstrb/tuser/tvalid/tlast, tready out)
//   m_axis_*                     master stream (tdata/tstrb/tuser/tvalid/tlast, tready in)
//   sw_rst                       synchronous clear: refill bucket, restart interval
//   rate_lim_en                  1 = token bucket active, 0 = bypass
//   tokens_per_interval          bytes credited per interval
//   interval_cycles              interval length minus 1
//   bucket_max                   burst cap in bytes
//   tokens                       current signed token count
//   throttled                    a packet is waiting at its boundary for tokens
//
// Optional build macro: RATE_LIMITER_STATS_EN
//   When defined, adds stat_pkts (packets passed) and stat_throttle_cycles
//   (cycles spent throttled). Both are 32-bit wrapping counters, cleared by
//   axi_areset or sw_rst.
// ---------------------------------------------------------------------------
module nf10_rate_limiter_token_bucket #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_TOKEN_WIDTH        = 32,
    parameter int C_INTERVAL_WIDTH     = 16
) (
    input  logic                              axi_aclk,
    input  logic                              axi_areset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    input  logic                              sw_rst,
    input  logic                              rate_lim_en,
    input  logic [C_TOKEN_WIDTH-2:0]          tokens_per_interval,
    input  logic [C_INTERVAL_WIDTH-1:0]       interval_cycles,
    input  logic [C_TOKEN_WIDTH-2:0]          bucket_max,
    output logic signed [C_TOKEN_WIDTH-1:0]   tokens,
    output logic                              throttled
`ifdef RATE_LIMITER_STATS_EN
    ,
    output logic [31:0]                       stat_pkts,
    output logic [31:0]                       stat_throttle_cycles
`endif
);

    localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int TW1    = C_TOKEN_WIDTH + 1;

    typedef enum logic {IDLE = 1'b0, PASS = 1'b1} state_t;

    state_t                          state_q, state_d;
    logic signed [C_TOKEN_WIDTH-1:0] tokens_q, tokens_d;
    logic [C_INTERVAL_WIDTH-1:0]     icnt_q, icnt_d;

    logic                            tokens_pos;
    logic                            gate;
    logic                            xfer;
    logic                            wrap;
    logic [C_TOKEN_WIDTH-2:0]        credit;
    logic [C_TOKEN_WIDTH:0]          debit;
    logic signed [C_TOKEN_WIDTH:0]   sum_ext;
    logic signed [C_TOKEN_WIDTH:0]   bmax_ext;
    logic signed [C_TOKEN_WIDTH:0]   min_ext;

    // Zero-latency pass-through datapath.
    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tstrb = s_axis_tstrb;
    assign m_axis_tuser = s_axis_tuser;
    assign m_axis_tlast = s_axis_tlast;

    // Strictly positive: sign bit clear and not zero.
    assign tokens_pos = ~tokens_q[C_TOKEN_WIDTH-1] & (|tokens_q);

    // Once inside a packet (PASS) the gate stays open regardless of tokens.
    // Reset closes the gate combinationally, so both stream sides stall at once.
    assign gate = ~axi_areset & (~rate_lim_en | (state_q == PASS) | tokens_pos);

    assign m_axis_tvalid = s_axis_tvalid & gate;
    assign s_axis_tready = m_axis_tready & gate;
    assign xfer          = s_axis_tvalid & s_axis_tready;

    // The reset term keeps throttled low while the bucket is held empty in reset.
    assign throttled = ~axi_areset & rate_lim_en & (state_q == IDLE) &
                       s_axis_tvalid & ~tokens_pos;

    assign tokens = tokens_q;

    // Framing tracker. It runs in bypass as well, so enabling the limiter
    // mid-packet only takes effect at the next packet start.
    always_comb begin
        state_d = state_q;
        if (xfer) begin
            state_d = s_axis_tlast ? IDLE : PASS;
        end
    end

    // Byte count of the current beat. It is zero unless the beat transfers.
    always_comb begin
        debit = '0;
        for (int i = 0; i < STRB_W; i++) begin
            debit = debit + TW1'(s_axis_tstrb[i]);
        end
        if (!xfer) begin
            debit = '0;
        end
    end

    // The bucket arithmetic uses one extra bit, so the raw sum never wraps
    // before it is clamped.
    assign wrap     = (icnt_q >= interval_cycles);
    assign credit   = wrap ? tokens_per_interval : '0;
    assign sum_ext  = {tokens_q[C_TOKEN_WIDTH-1], tokens_q} + {2'b00, credit} - debit;
    assign bmax_ext = {2'b00, bucket_max};
    assign min_ext  = {2'b11, {(C_TOKEN_WIDTH-1){1'b0}}};

    always_comb begin
        tokens_d = tokens_q;
        icnt_d   = icnt_q;
        if (!rate_lim_en || sw_rst) begin
            // Bypass and the software clear both refill the bucket and restart
            // the interval.
            tokens_d = bmax_ext[C_TOKEN_WIDTH-1:0];
            icnt_d   = '0;
        end else begin
            icnt_d = wrap ? '0 : icnt_q + C_INTERVAL_WIDTH'(1);
            if (sum_ext > bmax_ext) begin
                tokens_d = bmax_ext[C_TOKEN_WIDTH-1:0];
            end else if (sum_ext < min_ext) begin
                tokens_d = min_ext[C_TOKEN_WIDTH-1:0];
            end else begin
                tokens_d = sum_ext[C_TOKEN_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q  <= IDLE;
            tokens_q <= '0;
            icnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            tokens_q <= tokens_d;
            icnt_q   <= icnt_d;
        end
    end

`ifdef RATE_LIMITER_STATS_EN
    logic [31:0] stat_pkts_q, stat_pkts_d;
    logic [31:0] stat_thr_q, stat_thr_d;

    always_comb begin
        stat_pkts_d = stat_pkts_q;
        stat_thr_d  = stat_thr_q;
        if (sw_rst) begin
            stat_pkts_d = '0;
            stat_thr_d  = '0;
        end else begin
            if (xfer && s_axis_tlast) begin
                stat_pkts_d = stat_pkts_q + 32'd1;
            end
            if (throttled) begin
                stat_thr_d = stat_thr_q + 32'd1;
            end
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            stat_pkts_q <= '0;
            stat_thr_q  <= '0;
        end else begin
            stat_pkts_q <= stat_pkts_d;
            stat_thr_q  <= stat_thr_d;
        end
    end

    assign stat_pkts            = stat_pkts_q;
    assign stat_throttle_cycles = stat_thr_q;
`endif

endmodule
